// File: rtl/uart_rx_fifo.sv
// Receive character FIFO: 16 x (8 data + break/parity/framing flags) with occupancy, sticky overrun and aggregate error.
// Latency: data_out valid the cycle after a push into an empty FIFO; full FIFO drops pushes (pop-in-same-cycle excepted).
module uart_rx_fifo #(
    parameter int fifo_width     = 11,
    parameter int fifo_depth     = 16,
    parameter int fifo_pointer_w = 4,
    parameter int fifo_counter_w = 5
) (
    input  logic                      clk,
    input  logic                      wb_rst_i,
    input  logic [fifo_width-1:0]     data_in,
    input  logic                      push,
    input  logic                      pop,
    input  logic                      fifo_reset,
    input  logic                      reset_status,
    output logic [fifo_width-1:0]     data_out,
    output logic [fifo_counter_w-1:0] count,
    output logic                      overrun,
    output logic                      error_bit
);

    localparam logic [fifo_counter_w-1:0] depth_c = fifo_counter_w'(fifo_depth);

    logic [fifo_width-1:0]     mem [fifo_depth];
    logic [fifo_pointer_w-1:0] top;
    logic [fifo_pointer_w-1:0] bottom;
    logic [fifo_counter_w-1:0] count_q;
    logic                      full;
    logic                      empty;
    logic                      do_push;
    logic                      do_pop;

    assign full    = (count_q == depth_c);
    assign empty   = (count_q == '0);
    assign do_pop  = pop && !empty;
    // A full FIFO still accepts a push when a pop frees the head slot in the same cycle.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            top     <= '0;
            bottom  <= '0;
            count_q <= '0;
            for (int i = 0; i < fifo_depth; i++) begin
                mem[i] <= '0;
            end
        end else if (fifo_reset) begin
            top     <= '0;
            bottom  <= '0;
            count_q <= '0;
            for (int i = 0; i < fifo_depth; i++) begin
                mem[i][2:0] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[top] <= data_in;
                top      <= top + 1'b1;
            end
            if (do_pop) begin
                bottom <= bottom + 1'b1;
                // Popped flags are cleared so error_bit forgets them, unless the slot is being refilled now.
                if (!(do_push && (top == bottom))) begin
                    mem[bottom][2:0] <= '0;
                end
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Setting on a dropped character beats a simultaneous status-read clear.
    always_ff @(posedge clk or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            overrun <= 1'b0;
        end else if (fifo_reset) begin
            overrun <= 1'b0;
        end else if (push && !pop && full) begin
            overrun <= 1'b1;
        end else if (reset_status) begin
            overrun <= 1'b0;
        end
    end

    always_comb begin
        logic [fifo_pointer_w-1:0] offset;
        error_bit = 1'b0;
        offset    = '0;
        for (int i = 0; i < fifo_depth; i++) begin
            offset = fifo_pointer_w'(i) - bottom;
            if (fifo_counter_w'(offset) < count_q) begin
                error_bit = error_bit | (|mem[i][2:0]);
            end
        end
    end

    assign data_out = mem[bottom];
    assign count    = count_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: hand-computed expectations checked with immediate assertions.
module tb_uart_rx_fifo;

    logic        clk = 1'b0;
    logic        wb_rst_i;
    logic [10:0] data_in;
    logic        push;
    logic        pop;
    logic        fifo_reset;
    logic        reset_status;
    logic [10:0] data_out;
    logic [4:0]  count;
    logic        overrun;
    logic        error_bit;

    int checks = 0;
    int errors = 0;

    uart_rx_fifo dut (
        .clk          (clk),
        .wb_rst_i     (wb_rst_i),
        .data_in      (data_in),
        .push         (push),
        .pop          (pop),
        .fifo_reset   (fifo_reset),
        .reset_status (reset_status),
        .data_out     (data_out),
        .count        (count),
        .overrun      (overrun),
        .error_bit    (error_bit)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are read at the same point.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_push(input logic [10:0] d);
        data_in = d;
        push    = 1'b1;
        tick();
        push    = 1'b0;
    endtask

    task automatic do_pop();
        pop = 1'b1;
        tick();
        pop = 1'b0;
    endtask

    initial begin
        wb_rst_i     = 1'b0;
        data_in      = '0;
        push         = 1'b0;
        pop          = 1'b0;
        fifo_reset   = 1'b0;
        reset_status = 1'b0;
        #12;
        chk("rst_count",    32'(count),     32'd0);
        chk("rst_data_out", 32'(data_out),  32'h0);
        chk("rst_overrun",  32'(overrun),   32'd0);
        chk("rst_error",    32'(error_bit), 32'd0);
        wb_rst_i = 1'b1;
        tick();

        // Single character round trip
        do_push(11'h208);
        chk("single_count", 32'(count),     32'd1);
        chk("single_data",  32'(data_out),  32'h208);
        chk("single_error", 32'(error_bit), 32'd0);
        do_pop();
        chk("single_pop_count", 32'(count), 32'd0);
        do_pop();
        chk("empty_pop_ignored", 32'(count), 32'd0);

        // Fill, overflow, drain in order
        for (int i = 0; i < 16; i++) do_push(11'(i << 3));
        chk("full_count",   32'(count),     32'd16);
        chk("full_overrun", 32'(overrun),   32'd0);
        chk("full_error",   32'(error_bit), 32'd0);
        do_push(11'h550);
        chk("ovf_overrun", 32'(overrun), 32'd1);
        chk("ovf_count",   32'(count),   32'd16);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("drain_data%0d", i), 32'(data_out[10:3]), 32'(i));
            do_pop();
        end
        chk("drain_count", 32'(count), 32'd0);
        chk("drain_overrun_sticky", 32'(overrun), 32'd1);

        reset_status = 1'b1;
        tick();
        reset_status = 1'b0;
        chk("status_clear", 32'(overrun), 32'd0);

        // Break flag aggregated, then cleared by pop
        do_push(11'h004);
        do_push(11'h2A8);
        chk("brk_error", 32'(error_bit), 32'd1);
        chk("brk_count", 32'(count),     32'd2);
        do_pop();
        chk("brk_pop_error", 32'(error_bit), 32'd0);
        chk("brk_pop_data",  32'(data_out),  32'h2A8);
        do_pop();

        // Simultaneous push/pop while full
        for (int i = 0; i < 16; i++) do_push(11'((i + 16) << 3));
        chk("pp_pre_head", 32'(data_out[10:3]), 32'h10);
        data_in = 11'h3F8;
        push    = 1'b1;
        pop     = 1'b1;
        tick();
        push    = 1'b0;
        pop     = 1'b0;
        chk("pp_full_count",   32'(count),          32'd16);
        chk("pp_full_overrun", 32'(overrun),        32'd0);
        chk("pp_full_head",    32'(data_out[10:3]), 32'h11);

        // Simultaneous push/pop while empty behaves as push
        fifo_reset = 1'b1;
        tick();
        fifo_reset = 1'b0;
        chk("flush_count", 32'(count), 32'd0);
        data_in = 11'h198;
        push    = 1'b1;
        pop     = 1'b1;
        tick();
        push    = 1'b0;
        pop     = 1'b0;
        chk("pp_empty_count", 32'(count),    32'd1);
        chk("pp_empty_data",  32'(data_out), 32'h198);
        do_pop();

        // Overflow set beats status clear
        for (int i = 0; i < 16; i++) do_push(11'(i << 3));
        do_push(11'h7F8);
        chk("ovf2_set", 32'(overrun), 32'd1);
        reset_status = 1'b1;
        tick();
        chk("ovf2_clear", 32'(overrun), 32'd0);
        data_in = 11'h7F8;
        push    = 1'b1;
        tick();
        push         = 1'b0;
        reset_status = 1'b0;
        chk("ovf_set_wins", 32'(overrun), 32'd1);
        chk("ovf_set_count", 32'(count),  32'd16);

        // Flush with five entries, one carrying a parity error
        for (int i = 0; i < 12; i++) do_pop();
        chk("pre_flush_head", 32'(data_out[10:3]), 32'd12);
        do_push(11'h112);
        chk("pre_flush_count", 32'(count),     32'd5);
        chk("pre_flush_error", 32'(error_bit), 32'd1);
        fifo_reset = 1'b1;
        tick();
        fifo_reset = 1'b0;
        chk("flush5_count",   32'(count),     32'd0);
        chk("flush5_error",   32'(error_bit), 32'd0);
        chk("flush5_overrun", 32'(overrun),   32'd0);
        do_push(11'h1E1);
        chk("post_flush_data",  32'(data_out),  32'h1E1);
        chk("post_flush_count", 32'(count),     32'd1);
        chk("post_flush_error", 32'(error_bit), 32'd1);
        do_pop();
        chk("post_flush_pop_count", 32'(count),     32'd0);
        chk("post_flush_pop_error", 32'(error_bit), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- 16-entry first-in/first-out buffer for received UART characters.
- Sits between the UART receive state machine (pushes) and the register interface (pops).
- Each entry is 8 data bits plus 3 per-character error flags: break, parity, framing.
- Reports occupancy, overrun, and an aggregate "any stored character has an error" flag for the line status register.

Parameters:
- fifo_width, 11: entry width; bits [10:3] data, bit 2 break, bit 1 parity error, bit 0 framing error.
- fifo_depth, 16: number of entries.
- fifo_pointer_w, 4: read/write pointer width; log2(fifo_depth).
- fifo_counter_w, 5: occupancy counter width; holds 0..fifo_depth.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- wb_rst_i  in  1  asynchronous, active-low reset.
- data_in  in  fifo_width  character and flags to store.
- push  in  1  single-cycle write strobe.
- pop  in  1  single-cycle read strobe.
- fifo_reset  in  1  synchronous flush.
- reset_status  in  1  synchronous clear of the overrun flag (line status read).
- data_out  out  fifo_width  entry at the read pointer (head).
- count  out  fifo_counter_w  number of valid entries.
- overrun  out  1  sticky flag: a character was lost to a full FIFO.
- error_bit  out  1  OR of bits [2:0] over all valid entries.

Behaviour:
- Reset (wb_rst_i low, asynchronous):
  - Read and write pointers = 0; count = 0; overrun = 0.
  - All storage cleared to 0, so data_out = 0 and error_bit = 0.
- Push only, count < depth: write data_in at the write pointer; write pointer +1 (mod 16); count +1.
- Push only, count == depth:
  - Data is discarded; pointers and count are unchanged.
  - overrun is set to 1 on the next edge.
- Pop only, count > 0:
  - Clear the 3 flag bits of the head slot.
  - Read pointer +1 (mod 16); count -1.
- Pop only, count == 0: ignored; nothing changes.
- Push and pop together:
  - count == 0: treated as a push only, so count becomes 1.
  - 0 < count ≤ depth: both happen, both pointers advance, count is unchanged, overrun is not set.
  - The popped slot's flags are cleared unless it is also the slot being written.
- Pointers wrap 15 -> 0; count saturates within 0..16.
- data_out:
  - Combinational read of the slot at the read pointer.
  - Valid the cycle after a push into an empty FIFO.
  - Changes the cycle after a pop.
  - When count == 0 it shows stale slot contents; the consumer must qualify it with count.
- error_bit: combinational OR of flag bits [2:0] across valid entries. Popping the last erroneous entry clears it in the following cycle.
- fifo_reset (synchronous, has priority over push/pop):
  - Pointers = 0; count = 0.
  - All flag bits cleared, so error_bit = 0.
  - overrun cleared.
  - Data bytes may be left as they are.
- reset_status: clears overrun on the next edge. If a push into a full FIFO happens in the same cycle, the set wins (overrun = 1).
- No data-dependent latency: all counters and flags update on the edge following the strobe.

Test Plan:
- Reset, then push 0x41<<3 (data 0x41, no flags) -> next cycle count=1, data_out=0x208, error_bit=0; pop -> count=0.
- Push 16 entries with data 0..15 -> count=16, overrun=0. Push a 17th -> overrun=1, count=16. Pop all 16 -> data_out sequence 0..15 (data field), count=0.
- Push {0x00,3'b100} (break) then {0x55,3'b000} -> error_bit=1. Pop once -> error_bit=0, data_out data=0x55.
- With count=16, assert push and pop together -> count stays 16, overrun stays 0, head advances. With count=0, push+pop -> count=1.
- Overrun set, then pulse reset_status -> overrun=0. Assert reset_status together with an overflowing push -> overrun stays 1.
- With 5 entries including one parity error, pulse fifo_reset -> count=0, error_bit=0, overrun=0. Then a push/pop round-trip works from pointer 0.
